// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the toggle-triggered UART transmitter.
//   uart_state_e   - transmitter FSM states
//   clks_per_bit() - clock cycles per serial bit for a given clock/baud pair
//   UART_DATA_BITS - data bits per frame (8N1)
//   UART_STOP_BITS - stop bits per frame
package uart_pkg;

   localparam int unsigned UART_DATA_BITS = 8;
   localparam int unsigned UART_STOP_BITS = 1;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } uart_state_e;

   // Integer division; the result must be at least 2 for the baud counter to work.
   function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                input int unsigned baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_toggle_tx_if.sv
// uart_toggle_tx_if: request/data/status bundle between the RAM read-address
// generator (master) and the UART transmitter (slave).
//   tx_trig    - toggle request, any level change asks for one frame
//   tx_data    - byte to send, sampled when the frame starts
//   tx_busy    - high from start bit to end of stop bit
//   tx         - serial line, idles high
//   frame_done - one-cycle pulse in the last cycle of the stop bit
interface uart_toggle_tx_if;
   import uart_pkg::*;

   logic                      tx_trig;
   logic [UART_DATA_BITS-1:0] tx_data;
   logic                      tx_busy;
   logic                      tx;
   logic                      frame_done;

   modport master (
      output tx_trig,
      output tx_data,
      input  tx_busy,
      input  tx,
      input  frame_done
   );

   modport slave (
      input  tx_trig,
      input  tx_data,
      output tx_busy,
      output tx,
      output frame_done
   );

endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter.
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   clear - hold the count at zero (used while the transmitter is idle)
//   tick  - high in the last cycle of each bit period
// Counts 0..CLKS_PER_BIT-1 and wraps on tick, so every new bit starts at zero.
module uart_baud_cnt #(
   parameter int unsigned CLKS_PER_BIT = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

   logic [CntW-1:0] cnt_q;

   assign tick = (cnt_q == CntMax);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clear || tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CntW'(1);
      end
   end

endmodule

// File: rtl/uart_toggle_tx.sv
// uart_toggle_tx: 8N1 LSB-first UART transmitter started by level changes on tx_trig.
//   clk   - system clock, all state on rising edge
//   rst_n - asynchronous active-low reset
//   bus   - slave side of uart_toggle_tx_if (tx_trig/tx_data in; tx_busy/tx/frame_done out)
// A request arriving while a frame is in flight is held in a one-deep pending flag and
// served one cycle after tx_busy falls, so the generator always sees a busy falling edge.
module uart_toggle_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned BAUD     = 115200
) (
   input logic             clk,
   input logic             rst_n,
   uart_toggle_tx_if.slave bus
);

   localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
   localparam int unsigned IdxW         = $clog2(UART_DATA_BITS);

   logic                      trig_s1_q, trig_s2_q, trig_ref_q;
   logic [1:0]                warm_q;
   logic                      trig_edge;
   logic                      pending_q, pending_d;
   uart_state_e               state_q, state_d;
   logic [IdxW-1:0]           bit_idx_q, bit_idx_d;
   logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
   logic                      tx_q, tx_d;
   logic                      busy_q, busy_d;
   logic                      tick;
   logic                      cnt_clear;

   // Synchronizer and edge reference. warm_q masks edges until the synchronizer has
   // filled after reset, so a tx_trig level held high across reset is not a request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_s1_q  <= 1'b0;
         trig_s2_q  <= 1'b0;
         trig_ref_q <= 1'b0;
         warm_q     <= 2'd0;
      end else begin
         trig_s1_q  <= bus.tx_trig;
         trig_s2_q  <= trig_s1_q;
         trig_ref_q <= trig_s2_q;
         if (warm_q != 2'd3) begin
            warm_q <= warm_q + 2'd1;
         end
      end
   end

   assign trig_edge = (warm_q == 2'd3) && (trig_s2_q != trig_ref_q);

   // Counter is held at zero in idle and wraps on its own tick, so it restarts at
   // zero on every state entry.
   assign cnt_clear = (state_q == StIdle);

   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .clear(cnt_clear),
      .tick (tick)
   );

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      tx_d      = 1'b1;
      busy_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (trig_edge || pending_q) begin
               state_d   = StStart;
               shreg_d   = bus.tx_data;
               pending_d = 1'b0;
               bit_idx_d = '0;
            end
         end
         StStart: begin
            if (tick) begin
               state_d = StData;
            end
         end
         StData: begin
            if (tick) begin
               if (bit_idx_q == IdxW'(UART_DATA_BITS - 1)) begin
                  state_d = StStop;
               end else begin
                  bit_idx_d = bit_idx_q + IdxW'(1);
               end
            end
         end
         StStop: begin
            if (tick) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Includes the STOP->IDLE cycle; the request is then served from idle next cycle.
      if (trig_edge && (state_q != StIdle)) begin
         pending_d = 1'b1;
      end

      // Outputs are registered from the next state so they change with the state.
      unique case (state_d)
         StIdle:  tx_d = 1'b1;
         StStart: tx_d = 1'b0;
         StData:  tx_d = shreg_d[bit_idx_d];
         StStop:  tx_d = 1'b1;
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         pending_q <= 1'b0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.tx         = tx_q;
   assign bus.tx_busy    = busy_q;
   assign bus.frame_done = (state_q == StStop) && tick;

endmodule

// File: tb/tb_uart_toggle_tx.sv
// tb_uart_toggle_tx: directed, table-driven bench for uart_toggle_tx at 8 clk/bit.
module tb_uart_toggle_tx;

   logic clk = 1'b0;
   logic rst_n;

   uart_toggle_tx_if bus ();

   uart_toggle_tx #(
      .CLK_FREQ(8),
      .BAUD    (1)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;  // line levels, bit 0 sent first
   } vec_t;

   vec_t single_vecs[4];
   vec_t gen_vecs[4];

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_vec++;
      if (act < lo || act > hi) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic toggle_trig();
      bus.tx_trig = ~bus.tx_trig;
   endtask

   // Negedges until tx_busy is seen high; -1 if it never rises within the budget.
   task automatic wait_start(output int n);
      n = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.tx_busy) begin
            n = i;
            break;
         end
      end
   endtask

   // Called on the first negedge of the start bit. Samples each bit mid-period and can
   // inject up to two trig toggles (the first also loads new_data) at given cycles.
   task automatic capture(input int inj_a, input logic [7:0] new_data, input int inj_b,
                          output logic [9:0] bits, output int len, output int done_cnt,
                          output int done_at);
      int c;
      bits     = '0;
      done_cnt = 0;
      done_at  = -1;
      c        = 0;
      while (bus.tx_busy && c < 200) begin
         if ((c % 8) == 3 && (c / 8) < 10) bits[c/8] = bus.tx;
         if (bus.frame_done) begin
            done_cnt++;
            done_at = c;
         end
         if (c == inj_a) begin
            bus.tx_data = new_data;
            toggle_trig();
         end
         if (c == inj_b) toggle_trig();
         c++;
         @(negedge clk);
      end
      len = c;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [9:0] bits;
      int lat, len, dn, dat, gap, seen;

      single_vecs[0] = '{data: 8'hA5, frame: 10'b1101001010};
      single_vecs[1] = '{data: 8'h00, frame: 10'b1000000000};
      single_vecs[2] = '{data: 8'hFF, frame: 10'b1111111110};
      single_vecs[3] = '{data: 8'h81, frame: 10'b1100000010};
      gen_vecs[0]    = '{data: 8'h11, frame: 10'b1000100010};
      gen_vecs[1]    = '{data: 8'h22, frame: 10'b1001000100};
      gen_vecs[2]    = '{data: 8'h33, frame: 10'b1001100110};
      gen_vecs[3]    = '{data: 8'h44, frame: 10'b1010001000};

      rst_n       = 1'b0;
      bus.tx_trig = 1'b0;
      bus.tx_data = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_tx", int'(bus.tx), 1);
      check("reset_busy", int'(bus.tx_busy), 0);
      check("reset_done", int'(bus.frame_done), 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Single frames; tx_data is inverted after start to prove it was latched.
      for (int i = 0; i < 4; i++) begin
         bus.tx_data = single_vecs[i].data;
         toggle_trig();
         wait_start(lat);
         check_range($sformatf("single%0d_latency", i), lat, 2, 3);
         bus.tx_data = ~single_vecs[i].data;
         capture(-1, 8'h00, -1, bits, len, dn, dat);
         check($sformatf("single%0d_bits", i), int'(bits), int'(single_vecs[i].frame));
         check($sformatf("single%0d_busy_len", i), len, 80);
         check($sformatf("single%0d_done_cnt", i), dn, 1);
         check($sformatf("single%0d_done_at", i), dat, 79);
         repeat (4) @(negedge clk);
      end

      // Toggle during frame: pending request served exactly one idle cycle later.
      bus.tx_data = 8'h3C;
      toggle_trig();
      wait_start(lat);
      capture(20, 8'hC3, -1, bits, len, dn, dat);
      check("pend_f1_bits", int'(bits), int'(10'b1001111000));
      wait_start(gap);
      check("pend_gap", gap, 1);
      bus.tx_data = 8'h00;
      capture(-1, 8'h00, -1, bits, len, dn, dat);
      check("pend_f2_bits", int'(bits), int'(10'b1110000110));
      check("pend_f2_len", len, 80);
      repeat (4) @(negedge clk);

      // Two edges while busy: exactly one extra frame.
      bus.tx_data = 8'h5A;
      toggle_trig();
      wait_start(lat);
      capture(10, 8'h96, 30, bits, len, dn, dat);
      check("dbl_f1_bits", int'(bits), int'(10'b1010110100));
      wait_start(gap);
      check("dbl_gap", gap, 1);
      capture(-1, 8'h00, -1, bits, len, dn, dat);
      check("dbl_f2_bits", int'(bits), int'(10'b1100101100));
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.tx_busy) seen++;
      end
      check("dbl_no_third", seen, 0);

      // Reset mid-frame with tx_trig left high afterwards.
      rst_n       = 1'b0;
      bus.tx_trig = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      bus.tx_data = 8'h77;
      toggle_trig();
      wait_start(lat);
      repeat (35) @(negedge clk);
      check("rst_midframe_busy", int'(bus.tx_busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_tx", int'(bus.tx), 1);
      check("rst_async_busy", int'(bus.tx_busy), 0);
      check("rst_async_done", int'(bus.frame_done), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.tx_busy || !bus.tx) seen++;
      end
      check("rst_no_frame", seen, 0);

      // Address-generator loop: advance and toggle on each tx_busy falling edge.
      bus.tx_data = gen_vecs[0].data;
      toggle_trig();
      for (int a = 0; a < 4; a++) begin
         wait_start(lat);
         check_range($sformatf("gen%0d_latency", a), lat, 2, 3);
         capture(-1, 8'h00, -1, bits, len, dn, dat);
         check($sformatf("gen%0d_bits", a), int'(bits), int'(gen_vecs[a].frame));
         if (a < 3) begin
            bus.tx_data = gen_vecs[a+1].data;
            toggle_trig();
         end
      end
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.tx_busy) seen++;
      end
      check("gen_stops_after_4", seen, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
